sisc_ctrl_mc: RTL and testbench

Parametrised multi-cycle control FSM for the SISC datapath. It is the successor of the fixed five-state controller and adds four things:
- Full memory-instruction sequencing (LOD/STR/SWP), with a req/ack handshake and a bounded wait.
- A corrected branch-condition table.
- A proper HALT state instead of simulation stop.
- A sticky fault state.

It sits between the instruction register / status register and the PC, register file, ALU, mux selects and data-memory interface.

---
 rtl/sisc_ctrl_pkg.sv | 39 +++
 rtl/sisc_br_cond.sv | 36 +++
 rtl/sisc_ctrl_mc.sv | 187 ++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg -- shared constants for the SISC multi-cycle controller.
//   state_e      : controller state encoding
//   OPC_*        : opcode values (NOOP..HLT)
//   AM_IMM       : mm field value selecting the immediate addressing form
//   ALU_*        : alu_op function codes
package sisc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START0  = 4'd0,
        ST_START1  = 4'd1,
        ST_FETCH   = 4'd2,
        ST_DECODE  = 4'd3,
        ST_EXECUTE = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_WB2     = 4'd7,
        ST_HALT    = 4'd8,
        ST_FAULT   = 4'd9
    } state_e;

    localparam int unsigned OPC_NOOP = 0;
    localparam int unsigned OPC_LOD  = 1;
    localparam int unsigned OPC_STR  = 2;
    localparam int unsigned OPC_SWP  = 3;
    localparam int unsigned OPC_BRA  = 4;
    localparam int unsigned OPC_BRR  = 5;
    localparam int unsigned OPC_BNE  = 6;
    localparam int unsigned OPC_BNR  = 7;
    localparam int unsigned OPC_ALU  = 8;
    localparam int unsigned OPC_HLT  = 15;

    localparam int unsigned AM_IMM = 8;

    localparam logic [1:0] ALU_REG  = 2'b00;  // ALU_OP, register form
    localparam logic [1:0] ALU_IMM  = 2'b01;  // ALU_OP, immediate form
    localparam logic [1:0] ALU_MREG = 2'b10;  // memory op, register form (also idle value)
    localparam logic [1:0] ALU_MIMM = 2'b11;  // memory op, immediate form

endpackage

// File: rtl/sisc_br_cond.sv
// sisc_br_cond -- combinational branch-condition evaluation.
//   opcode_i : IR opcode field
//   mm_i     : IR condition mask
//   stat_i   : status register
//   is_br_o  : opcode is one of BRA/BRR/BNE/BNR
//   taken_o  : branch condition satisfied
//   br_sel_o : 1 = absolute target (BRA/BNE), 0 = relative (BRR/BNR)
module sisc_br_cond
    import sisc_ctrl_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int CC_W = 4
) (
    input  logic [OP_W-1:0] opcode_i,
    input  logic [CC_W-1:0] mm_i,
    input  logic [CC_W-1:0] stat_i,
    output logic            is_br_o,
    output logic            taken_o,
    output logic            br_sel_o
);

    logic op_bra, op_brr, op_bne, op_bnr, hit;

    assign op_bra = (opcode_i == OP_W'(OPC_BRA));
    assign op_brr = (opcode_i == OP_W'(OPC_BRR));
    assign op_bne = (opcode_i == OP_W'(OPC_BNE));
    assign op_bnr = (opcode_i == OP_W'(OPC_BNR));

    // A zero mask never hits, so BRA/BRR fall through and BNE/BNR always jump.
    assign hit = |(stat_i & mm_i);

    assign is_br_o  = op_bra | op_brr | op_bne | op_bnr;
    assign taken_o  = ((op_bra | op_brr) & hit) | ((op_bne | op_bnr) & ~hit);
    assign br_sel_o = op_bra | op_bne;

endmodule

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc -- multi-cycle control FSM for the SISC datapath.
// Optional feature macro: SISC_CTRL_PERF_EN (retired / stall counters).
//   clk, rst_f        : clock (rising edge), async active-low reset
//   opcode, mm, stat  : IR opcode, IR mode/mask field, status register
//   mem_ack           : data-memory completion
//   rf_we..br_sel     : register-file / PC / IR / mux controls
//   mm_sel            : memory address from ALU (0) or PC (1)
//   alu_op            : ALU function
//   dm_we, mem_req    : data-memory write and request
//   halted, fault     : HALT reached, memory timeout occurred (sticky)
//   retired, stall_cnt: saturating perf counters (0 when feature is off)
module sisc_ctrl_mc
    import sisc_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int CC_W    = 4,
    parameter int ALUOP_W = 2,
    parameter int MEM_TO  = 15,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic [OP_W-1:0]    opcode,
    input  logic [CC_W-1:0]    mm,
    input  logic [CC_W-1:0]    stat,
    input  logic               mem_ack,
    output logic               rf_we,
    output logic               wb_sel,
    output logic               rb_sel,
    output logic               pc_sel,
    output logic               pc_write,
    output logic               pc_rst,
    output logic               ir_load,
    output logic               br_sel,
    output logic               mm_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               dm_we,
    output logic               mem_req,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        retired,
    output logic [15:0]        stall_cnt
);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              is_br, br_taken, br_abs;
    logic              op_lod, op_str, op_swp, op_alu, op_mem, op_imm;

    assign op_lod = (opcode == OP_W'(OPC_LOD));
    assign op_str = (opcode == OP_W'(OPC_STR));
    assign op_swp = (opcode == OP_W'(OPC_SWP));
    assign op_alu = (opcode == OP_W'(OPC_ALU));
    assign op_mem = op_lod | op_str | op_swp;
    assign op_imm = (mm == CC_W'(AM_IMM));

    sisc_br_cond #(.OP_W(OP_W), .CC_W(CC_W)) u_br_cond (
        .opcode_i (opcode),
        .mm_i     (mm),
        .stat_i   (stat),
        .is_br_o  (is_br),
        .taken_o  (br_taken),
        .br_sel_o (br_abs)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_START0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;          // anything outside MEM clears it, so each MEM entry starts at 0
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        br_sel   = 1'b0;
        mm_sel   = 1'b0;
        alu_op   = ALUOP_W'(ALU_MREG);
        dm_we    = 1'b0;
        mem_req  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_START0: begin
                pc_rst  = 1'b1;
                state_d = ST_START1;
            end
            ST_START1: begin
                pc_rst  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                mm_sel   = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode == OP_W'(OPC_HLT)) begin
                    state_d = ST_HALT;
                end else if (is_br) begin
                    br_sel   = br_abs;
                    pc_write = br_taken;
                    pc_sel   = br_taken;
                    state_d  = ST_FETCH;
                end else if (opcode == OP_W'(OPC_NOOP)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (op_alu) begin
                    alu_op  = op_imm ? ALUOP_W'(ALU_IMM) : ALUOP_W'(ALU_REG);
                    state_d = ST_WB;
                end else if (op_mem) begin
                    alu_op  = op_imm ? ALUOP_W'(ALU_MIMM) : ALUOP_W'(ALU_MREG);
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;     // opcodes 9..14 behave as NOOP
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                dm_we   = op_str;
                if (mem_ack) begin
                    state_d = op_str ? ST_FETCH : ST_WB;
                end else if (wait_q == TO_W'(MEM_TO - 1)) begin
                    // this is the MEM_TO-th cycle without an ack
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wb_sel  = op_lod | op_swp;
                state_d = op_swp ? ST_WB2 : ST_FETCH;
            end
            ST_WB2: begin
                rf_we   = 1'b1;
                rb_sel  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  state_d = ST_START0;
        endcase
    end

`ifdef SISC_CTRL_PERF_EN
    logic [15:0] retired_q, stall_q;
    logic        retire_ev, stall_ev;

    // MEM only returns to FETCH for STR, so no opcode qualifier is needed here.
    assign retire_ev = (state_d == ST_FETCH) &&
                       (state_q inside {ST_DECODE, ST_WB, ST_WB2, ST_MEM});
    assign stall_ev  = (state_q == ST_MEM) && !mem_ack;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire_ev && retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
            if (stall_ev  && stall_q   != 16'hFFFF) stall_q   <= stall_q + 16'd1;
        end
    end

    assign retired   = retired_q;
    assign stall_cnt = stall_q;
`else
    assign retired   = 16'h0;
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: each instruction is expanded into the list of
// per-cycle output vectors the controller must produce, queued, and checked
// on every falling edge. Directed cases pin cycle counts with literals.
module tb_sisc_ctrl_mc;

    localparam int MEM_TO = 15;
`ifdef SISC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode, mm, stat;
    logic        mem_ack;
    logic        rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mm_sel;
    logic [1:0]  alu_op;
    logic        dm_we, mem_req, halted, fault;
    logic [15:0] retired, stall_cnt;

    sisc_ctrl_mc #(.OP_W(4), .CC_W(4), .ALUOP_W(2), .MEM_TO(MEM_TO), .TO_W(8)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel), .pc_write(pc_write),
        .pc_rst(pc_rst), .ir_load(ir_load), .br_sel(br_sel), .mm_sel(mm_sel), .alu_op(alu_op),
        .dm_we(dm_we), .mem_req(mem_req), .halted(halted), .fault(fault),
        .retired(retired), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mm_sel;
        logic [1:0] alu_op;
        logic       dm_we, mem_req, halted, fault;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic [15:0] ret;
        logic [15:0] stl;
        string       tag;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0, n_pass = 0;
    int   m_ret = 0, m_stl = 0;                 // model perf counts
    int   n_mreq = 0, n_pcw = 0, n_rfwe = 0, n_rb = 0;

    task automatic chk(input string tag, input longint act, input longint want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic outs_t idle();
        outs_t o;
        o = '0;
        o.alu_op = 2'b10;
        return o;
    endfunction

    function automatic outs_t act_outs();
        outs_t a;
        a.rf_we = rf_we;     a.wb_sel = wb_sel;   a.rb_sel = rb_sel;   a.pc_sel = pc_sel;
        a.pc_write = pc_write; a.pc_rst = pc_rst; a.ir_load = ir_load; a.br_sel = br_sel;
        a.mm_sel = mm_sel;   a.alu_op = alu_op;   a.dm_we = dm_we;     a.mem_req = mem_req;
        a.halted = halted;   a.fault = fault;
        return a;
    endfunction

    task automatic push(input outs_t o, input string tag);
        exp_t x;
        x.o   = o;
        x.tag = tag;
        x.ret = PERF ? sat16(m_ret) : 16'h0;
        x.stl = PERF ? sat16(m_stl) : 16'h0;
        expq.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single compare point: one queued expectation per clock cycle.
    always @(negedge clk) begin : cmp
        exp_t x;
        if (expq.size() != 0) begin
            x = expq.pop_front();
            chk({x.tag, " outs"}, longint'(act_outs()), longint'(x.o));
            chk({x.tag, " counters"}, {retired, stall_cnt}, {x.ret, x.stl});
        end
    end

    always @(negedge clk) begin
        if (mem_req)  n_mreq++;
        if (pc_write) n_pcw++;
        if (rf_we)    n_rfwe++;
        if (rb_sel)   n_rb++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    // Called at posedge+1 with rst_f already low.
    task automatic release_reset();
        outs_t e;
        e = idle();
        e.pc_rst = 1'b1;
        opcode = 4'($urandom); mem_ack = 1'($urandom);
        push(e, "reset held");  step();
        rst_f = 1'b1;
        push(e, "start0");      step();
        push(e, "start1");      step();
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        m_ret = 0;
        m_stl = 0;
        release_reset();
    endtask

    // Drive one instruction from FETCH onward. delay = ack-less MEM cycles
    // before mem_ack; abort_at = MEM cycle at which rst_f is pulsed (0: none);
    // hold = cycles spent observing HALT/FAULT before reset.
    task automatic run_instr(input int op, input logic [3:0] mv, input logic [3:0] sv,
                             input int delay, input int abort_at, input int hold);
        outs_t e;
        bit    taken, is_mem, acked;
        opcode = 4'($urandom); mm = 4'($urandom); stat = 4'($urandom); mem_ack = 1'($urandom);
        e = idle(); e.ir_load = 1'b1; e.pc_write = 1'b1; e.mm_sel = 1'b1;
        push(e, "fetch"); step();

        opcode = 4'(op); mm = mv; stat = sv; mem_ack = 1'($urandom);
        e = idle();
        if (op == 15) begin
            push(e, "decode hlt"); step();
            for (int i = 0; i < hold; i++) begin
                mem_ack = 1'($urandom);
                e = idle(); e.halted = 1'b1;
                push(e, "halt"); step();
            end
            chk("halt flag", halted, 1);
            chk("halt pc_write", pc_write, 0);
            do_reset();
            return;
        end
        if (op >= 4 && op <= 7) begin
            taken = (op <= 5) ? ((sv & mv) != 4'h0) : ((sv & mv) == 4'h0);
            e.br_sel = (op == 4 || op == 6);
            e.pc_write = taken;
            e.pc_sel = taken;
            push(e, "decode branch"); m_ret++; step();
            return;
        end
        if (op == 0) begin
            push(e, "decode noop"); m_ret++; step();
            return;
        end
        push(e, "decode"); step();

        mem_ack = 1'($urandom);
        is_mem = (op >= 1 && op <= 3);
        e = idle();
        if (op == 8)     e.alu_op = (mv == 4'd8) ? 2'b01 : 2'b00;
        else if (is_mem) e.alu_op = (mv == 4'd8) ? 2'b11 : 2'b10;
        push(e, "execute"); step();
        if (op >= 9) return;

        if (is_mem) begin
            acked = 1'b0;
            for (int k = 1; k <= MEM_TO && !acked; k++) begin
                mem_ack = (k > delay);
                e = idle(); e.mem_req = 1'b1; e.dm_we = (op == 2);
                push(e, "mem");
                if (k == abort_at) begin
                    @(negedge clk); #2;
                    rst_f = 1'b0;
                    #1;
                    chk("async rst mem_req", mem_req, 0);
                    chk("async rst dm_we", dm_we, 0);
                    chk("async rst pc_rst", pc_rst, 1);
                    chk("async rst alu_op", alu_op, 2);
                    m_ret = 0; m_stl = 0;
                    @(posedge clk); #1;
                    release_reset();
                    return;
                end
                if (mem_ack) begin
                    acked = 1'b1;
                    if (op == 2) m_ret++;
                end else begin
                    m_stl++;
                end
                step();
            end
            if (!acked) begin
                for (int i = 0; i < hold; i++) begin
                    mem_ack = 1'($urandom);
                    e = idle(); e.fault = 1'b1;
                    push(e, "fault"); step();
                end
                chk("fault flag", fault, 1);
                chk("fault dm_we", dm_we, 0);
                chk("fault mem_req", mem_req, 0);
                do_reset();
                return;
            end
            if (op == 2) return;
        end

        mem_ack = 1'($urandom);
        e = idle(); e.rf_we = 1'b1; e.wb_sel = (op == 1 || op == 3);
        push(e, "wb");
        if (op != 3) m_ret++;
        step();
        if (op != 3) return;
        e = idle(); e.rf_we = 1'b1; e.rb_sel = 1'b1;
        push(e, "wb2"); m_ret++; step();
    endtask

    initial begin
        int b, b2, op, dly, ab;
        logic [3:0] mv;
        rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("reset pc_rst", pc_rst, 1);
        chk("reset alu_op", alu_op, 2);
        chk("reset mem_req", mem_req, 0);
        chk("reset pc_write", pc_write, 0);
        chk("reset retired", retired, 0);
        release_reset();

        b = n_rfwe; run_instr(8, 4'h0, 4'h0, 0, 0, 0);
        chk("alu rf_we cycles", n_rfwe - b, 1);

        b = n_pcw; run_instr(4, 4'b0010, 4'b0010, 0, 0, 0);
        chk("bra taken pc_write cycles", n_pcw - b, 2);
        b = n_pcw; run_instr(7, 4'b0010, 4'b0010, 0, 0, 0);
        chk("bnr untaken pc_write cycles", n_pcw - b, 1);
        b = n_pcw; run_instr(6, 4'b0000, 4'b1111, 0, 0, 0);
        chk("bne mm0 pc_write cycles", n_pcw - b, 2);
        b = n_pcw; run_instr(4, 4'b0000, 4'b1111, 0, 0, 0);
        chk("bra mm0 pc_write cycles", n_pcw - b, 1);

        b = n_mreq; run_instr(1, 4'd8, 4'h0, 3, 0, 0);
        chk("lod mem_req cycles", n_mreq - b, 4);
        chk("lod stall_cnt", stall_cnt, PERF ? 3 : 0);
        chk("retired after six", retired, PERF ? 6 : 0);

        b = n_rb; b2 = n_rfwe; run_instr(3, 4'h0, 4'h0, 1, 0, 0);
        chk("swp rb_sel cycles", n_rb - b, 1);
        chk("swp rf_we cycles", n_rfwe - b2, 2);

        b = n_mreq; run_instr(2, 4'h0, 4'h0, 100, 0, 3);
        chk("str timeout mem_req cycles", n_mreq - b, MEM_TO);
        b = n_mreq; run_instr(2, 4'h0, 4'h0, MEM_TO - 1, 0, 0);
        chk("str late ack mem_req cycles", n_mreq - b, MEM_TO);
        chk("str late ack no fault", fault, 0);

        b = n_pcw; run_instr(15, 4'h0, 4'h0, 0, 0, 20);
        chk("hlt pc_write cycles", n_pcw - b, 1);
        run_instr(2, 4'h0, 4'h0, 5, 3, 0);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 15);
            mv = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'($urandom);
            case ($urandom_range(0, 9))
                7:       dly = MEM_TO - 1;
                8:       dly = MEM_TO;
                9:       dly = 40;
                default: dly = $urandom_range(0, 4);
            endcase
            ab = 0;
            if (op >= 1 && op <= 3 && dly >= 2 && $urandom_range(0, 19) == 0)
                ab = $urandom_range(1, (dly < MEM_TO) ? dly : MEM_TO);
            run_instr(op, mv, 4'($urandom), dly, ab, $urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
